// File: rtl/bitwise_seq.sv
// ----------------------------------------------------------------------------
// bitwise_seq
//   Sequencer that runs an external 8-bit bitwise/carry unit over multi-byte
//   operands held in a dual-read, single-write byte memory. Each byte takes
//   three cycles: FETCH (present read addresses), EXEC (feed the unit and
//   capture its result and carry), and WRITE (store the result). cout of one
//   byte becomes cin of the next.
//
//   Optional feature (macro BITSEQ_ZFLAG_EN): adds output 'zero', which is 1
//   when every result byte of the last operation was 0x00.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, op, cin, dir, len   launch request and operation descriptor
//   base_a, base_b, base_q     first byte address of A, B and result
//   ra_addr/ra_data            read port A (data one cycle after address)
//   rb_addr/rb_data            read port B
//   wr_en, wr_addr, wr_data    write port, one strobe per byte
//   alu_a, alu_b, alu_op,
//   alu_cin, alu_q, alu_cout   connection to the combinational bitwise unit
//   busy, done, cout           status: running, end pulse, final carry
//   zero                       (BITSEQ_ZFLAG_EN only) all results were zero
// ----------------------------------------------------------------------------
module bitwise_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic              cin,
    input  logic              dir,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_q,
    output logic [ADDR_W-1:0] ra_addr,
    input  logic [7:0]        ra_data,
    output logic [ADDR_W-1:0] rb_addr,
    input  logic [7:0]        rb_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_cin,
    input  logic [7:0]        alu_q,
    input  logic              alu_cout,
    output logic              busy,
    output logic              done,
    output logic              cout
`ifdef BITSEQ_ZFLAG_EN
    ,
    output logic              zero
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [2:0]        op_r;
    logic              dir_r;
    logic [LEN_W-1:0]  len_r;
    logic [ADDR_W-1:0] base_a_r, base_b_r, base_q_r;
    logic [LEN_W-1:0]  idx;
    logic              carry_r;
    logic [7:0]        wdata_r;
    logic              cout_r;
`ifdef BITSEQ_ZFLAG_EN
    logic              zero_r;
`endif

    // Byte address for the current index; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base);
        return dir_r ? base - ADDR_W'(idx) : base + ADDR_W'(idx);
    endfunction

    // NOTE: every register here is small control/datapath state, so all of it
    // is reset; reset values also define the all-zero outputs after abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_r     <= '0;
            dir_r    <= 1'b0;
            len_r    <= '0;
            base_a_r <= '0;
            base_b_r <= '0;
            base_q_r <= '0;
            idx      <= '0;
            carry_r  <= 1'b0;
            wdata_r  <= '0;
            cout_r   <= 1'b0;
`ifdef BITSEQ_ZFLAG_EN
            zero_r   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state <= state_next;
            case (state)
                S_IDLE: if (start) begin
                    op_r     <= op;
                    dir_r    <= dir;
                    len_r    <= len;
                    base_a_r <= base_a;
                    base_b_r <= base_b;
                    base_q_r <= base_q;
                    idx      <= '0;
                    carry_r  <= cin;
`ifdef BITSEQ_ZFLAG_EN
                    zero_r   <= 1'b1;
`endif
                end
                S_EXEC: begin
                    wdata_r <= alu_q;
                    carry_r <= alu_cout;
`ifdef BITSEQ_ZFLAG_EN
                    zero_r  <= zero_r & (alu_q == 8'h00);
`endif
                end
                S_WRITE: begin
                    // Final carry is frozen here so it stays stable from done
                    // until the next start.
                    if (idx == len_r) cout_r <= carry_r;
                    else              idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        state_next = state;
        ra_addr    = '0;
        rb_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_cin    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: begin
                busy       = 1'b1;
                ra_addr    = byte_addr(base_a_r);
                rb_addr    = byte_addr(base_b_r);
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy       = 1'b1;
                ra_addr    = byte_addr(base_a_r);
                rb_addr    = byte_addr(base_b_r);
                alu_a      = ra_data;
                alu_b      = rb_data;
                alu_cin    = carry_r;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = byte_addr(base_q_r);
                state_next = (idx == len_r) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from state/registers so an async reset clears them
    // immediately.
    assign alu_op  = busy ? op_r : 3'd0;
    assign wr_data = wdata_r;
    assign cout    = cout_r;
`ifdef BITSEQ_ZFLAG_EN
    assign zero    = zero_r;
`endif

endmodule

// File: tb/tb_bitwise_seq.sv
// ----------------------------------------------------------------------------
// tb_bitwise_seq
//   Bench for bitwise_seq: provides a byte memory with registered read ports,
//   a behavioural bitwise unit, a reference model that predicts every write,
//   and a scoreboard that compares writes as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_bitwise_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic       cin = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] len = '0;
    logic [7:0] base_a = '0, base_b = '0, base_q = '0;
    logic [7:0] ra_addr, rb_addr, ra_data, rb_data;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] alu_a, alu_b, alu_q;
    logic [2:0] alu_op;
    logic       alu_cin, alu_cout;
    logic       busy, done, cout;
`ifdef BITSEQ_ZFLAG_EN
    logic       zero;
`endif

    int checks = 0;
    int failures = 0;

    bitwise_seq #(.ADDR_W(8), .LEN_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .dir(dir),
        .len(len), .base_a(base_a), .base_b(base_b), .base_q(base_q),
        .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_q(alu_q), .alu_cout(alu_cout),
        .busy(busy), .done(done), .cout(cout)
`ifdef BITSEQ_ZFLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural bitwise unit: returns {cout, q}.
    function automatic logic [8:0] alu_fn(input logic [2:0] f, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        case (f)
            3'd0:    return {c, ~(a & b)};
            3'd1:    return {c, a ^ b};
            3'd2:    return {a[7], a[6:0], c};
            3'd3:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
            default: return {c, a | b};
        endcase
    endfunction

    assign {alu_cout, alu_q} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

    // Byte memory: registered reads, write on the clock edge.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    always @(posedge clk) begin
        ra_data <= mem[ra_addr];
        rb_data <= mem[rb_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    typedef struct {
        logic [2:0] op;
        logic       cin;
        logic       dir;
        logic [2:0] len;
        logic [7:0] ba, bb, bq;
        bit         spam;
        int         exp_lat;
    } vec_t;

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t sb[$];

    // Per-byte expectations filled by the model.
    logic [7:0] exp_ra[8];
    logic [7:0] exp_a [8];
    logic       exp_ci[8];
    logic       exp_cout;
    logic       exp_zero;

    function automatic logic [7:0] offs(input logic [7:0] b, input logic d, input int i);
        return d ? b - 8'(i) : b + 8'(i);
    endfunction

    task automatic model(input vec_t v);
        logic c;
        logic [8:0] r;
        logic [7:0] aa, bb, qa;
        c = v.cin;
        exp_zero = 1'b1;
        for (int i = 0; i <= int'(v.len); i++) begin
            aa = offs(v.ba, v.dir, i);
            bb = offs(v.bb, v.dir, i);
            qa = offs(v.bq, v.dir, i);
            r = alu_fn(v.op, ref_mem[aa], ref_mem[bb], c);
            exp_ra[i] = aa;
            exp_a[i]  = ref_mem[aa];
            exp_ci[i] = c;
            c = r[8];
            if (r[7:0] != 8'h00) exp_zero = 1'b0;
            ref_mem[qa] = r[7:0];
            sb.push_back('{qa, r[7:0]});
        end
        exp_cout = c;
    endtask

    // Scoreboard consumer: every write strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (sb.size() == 0) begin
                check("extra_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic launch(input vec_t v);
        @(negedge clk);
        op = v.op; cin = v.cin; dir = v.dir; len = v.len;
        base_a = v.ba; base_b = v.bb; base_q = v.bq;
        start = 1'b1;
    endtask

    task automatic run_op(input vec_t v);
        int k;
        model(v);
        launch(v);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (done) break;
            check("busy_run", 32'(busy), 32'd1);
            check("alu_op", 32'(alu_op), 32'(v.op));
            if (k % 3 == 2 && (k - 2) / 3 <= 7) begin
                check("ra_addr", 32'(ra_addr), 32'(exp_ra[(k-2)/3]));
                check("alu_a", 32'(alu_a), 32'(exp_a[(k-2)/3]));
                check("alu_cin", 32'(alu_cin), 32'(exp_ci[(k-2)/3]));
            end
            start = v.spam && (k == 2 || k == 7);
            op = 3'd4;
        end
        check("latency", 32'(k), 32'(v.exp_lat));
        check("busy_done", 32'(busy), 32'd0);
        check("cout", 32'(cout), 32'(exp_cout));
`ifdef BITSEQ_ZFLAG_EN
        check("zero", 32'(zero), 32'(exp_zero));
`endif
        start = v.spam;   // start coinciding with done must be ignored
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("writes_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    vec_t vecs[5];
    vec_t rv, zv;
    logic [7:0] saved[4];

    initial begin
        vecs[0] = '{3'd0, 1'b0, 1'b0, 3'd0, 8'h10, 8'h11, 8'h20, 1'b0, 4};
        vecs[1] = '{3'd3, 1'b1, 1'b0, 3'd3, 8'h30, 8'h40, 8'h50, 1'b0, 13};
        vecs[2] = '{3'd1, 1'b0, 1'b1, 3'd2, 8'h01, 8'h81, 8'hC2, 1'b0, 10};
        vecs[3] = '{3'd2, 1'b1, 1'b0, 3'd2, 8'h60, 8'h60, 8'h60, 1'b1, 10};
        vecs[4] = '{3'd3, 1'b0, 1'b1, 3'd7, 8'h05, 8'hF0, 8'hA0, 1'b0, 25};

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
        poke(8'h10, 8'hF0);
        poke(8'h11, 8'hFF);
        poke(8'h33, 8'hFF);
        poke(8'h43, 8'h01);

        repeat (2) @(negedge clk);
        check("reset_outs", {ra_addr, rb_addr, wr_addr, wr_data}, 32'd0);
        check("reset_ctl", {alu_a, alu_b, alu_op, alu_cin, wr_en, busy, done, cout}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_op(vecs[i]);
        check("nand_lit", 32'(mem[8'h20]), 32'h0F);

        // Abort in the second WRITE of a 4-byte operation.
        rv = '{3'd1, 1'b0, 1'b0, 3'd3, 8'h90, 8'h98, 8'hB0, 1'b0, 13};
        for (int i = 0; i < 4; i++) saved[i] = ref_mem[8'hB0 + 8'(i)];
        model(rv);
        launch(rv);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_wr_en", 32'(wr_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outs", {ra_addr, rb_addr, wr_addr, wr_data}, 32'd0);
        check("abort_ctl", {alu_a, alu_b, alu_op, alu_cin, wr_en, busy, done, cout}, 32'd0);
        sb.delete();
        @(negedge clk);
        check("abort_b0", 32'(mem[8'hB0]), 32'(ref_mem[8'hB0]));
        check("abort_b1", 32'(mem[8'hB1]), 32'(saved[1]));
        for (int i = 1; i < 4; i++) ref_mem[8'hB0 + 8'(i)] = saved[i];
        rst_n = 1'b1;
        run_op(vecs[1]);

        // Zero-flag patterns.
        zv = '{3'd1, 1'b0, 1'b0, 3'd1, 8'hD0, 8'hD8, 8'hE0, 1'b0, 7};
        poke(8'hD0, 8'h5A); poke(8'hD8, 8'h5A);
        poke(8'hD1, 8'hC3); poke(8'hD9, 8'hC3);
        run_op(zv);
`ifdef BITSEQ_ZFLAG_EN
        check("zero_lit1", 32'(zero), 32'd1);
`endif
        poke(8'hD9, 8'hC2);
        run_op(zv);
`ifdef BITSEQ_ZFLAG_EN
        check("zero_lit0", 32'(zero), 32'd0);
`endif
        check("xor_b1", 32'(mem[8'hE1]), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
